// File: rtl/lsu_sram_if.sv
// Pipeline request/response bus and 256x32 data SRAM port of the MEM-stage load/store unit.
// The slave modport is the LSU view; master is the pipeline plus SRAM environment.
interface lsu_sram_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        CSram;
    logic [7:0]  Direc;
    logic [31:0] Datain;
    logic        LeerMem;
    logic        EscrMem;
    logic [31:0] Dataout;

    modport slave (
        input  req, we, size, uns, addr, wdata, Dataout,
        output busy, done, err, rdata, CSram, Direc, Datain, LeerMem, EscrMem
    );

    modport master (
        output req, we, size, uns, addr, wdata, Dataout,
        input  busy, done, err, rdata, CSram, Direc, Datain, LeerMem, EscrMem
    );
endinterface

// File: rtl/lsu_sram.sv
// Load/store unit driving the 256x32 data SRAM; sub-word stores use read-modify-write.
// Define LSU_SUBWORD_EN to build byte/halfword support; otherwise only word accesses succeed.
module lsu_sram (
    input  logic      clk,
    input  logic      rst_n,
    lsu_sram_if.slave bus
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP} state_t;

    state_t      state, state_nx;
    logic [7:0]  widx_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        bad;
    logic [31:0] ld_val;

`ifdef LSU_SUBWORD_EN
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
`endif

    // Misalignment/unsupported check looks at the live request; it is only used on acceptance.
    always_comb begin
        bad = (bus.size == 2'b01 && bus.addr[0]) ||
              (bus.size[1] && bus.addr[1:0] != 2'b00);
`ifndef LSU_SUBWORD_EN
        bad = bad || !bus.size[1];
`endif
    end

    always_comb begin
        ld_val = bus.Dataout;
`ifdef LSU_SUBWORD_EN
        half_lane = bus.Dataout[{lane_q[1], 4'b0000} +: 16];
        byte_lane = bus.Dataout[{lane_q, 3'b000} +: 8];
        if (!size_q[1]) begin
            if (size_q[0]) ld_val = {{16{half_lane[15] & ~uns_q}}, half_lane};
            else           ld_val = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
        end
        merged = merge_q;
        if (size_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else           merged[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            widx_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef LSU_SUBWORD_EN
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            merge_q <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req) begin
                widx_q  <= bus.addr[9:2];
                wdata_q <= bus.wdata;
                err_q   <= bad;
`ifdef LSU_SUBWORD_EN
                lane_q  <= bus.addr[1:0];
                size_q  <= bus.size;
                uns_q   <= bus.uns;
`endif
            end
            if (state == READ) rdata_q <= ld_val;
`ifdef LSU_SUBWORD_EN
            if (state == RMW_RD) merge_q <= bus.Dataout;
`endif
        end
    end

    always_comb begin
        state_nx    = state;
        bus.busy    = (state != IDLE);
        bus.done    = (state == RESP);
        bus.err     = (state == RESP) && err_q;
        bus.rdata   = rdata_q;
        bus.CSram   = 1'b0;
        bus.LeerMem = 1'b0;
        bus.EscrMem = 1'b0;
        bus.Direc   = '0;
        bus.Datain  = '0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bad)          state_nx = RESP;
                    else if (!bus.we) state_nx = READ;
`ifdef LSU_SUBWORD_EN
                    else if (!bus.size[1]) state_nx = RMW_RD;
`endif
                    else              state_nx = WRITE;
                end
            end
            READ: begin
                bus.CSram   = 1'b1;
                bus.LeerMem = 1'b1;
                bus.Direc   = widx_q;
                state_nx    = RESP;
            end
            WRITE: begin
                bus.CSram   = 1'b1;
                bus.EscrMem = 1'b1;
                bus.Direc   = widx_q;
                bus.Datain  = wdata_q;
                state_nx    = RESP;
            end
`ifdef LSU_SUBWORD_EN
            RMW_RD: begin
                bus.CSram   = 1'b1;
                bus.LeerMem = 1'b1;
                bus.Direc   = widx_q;
                state_nx    = RMW_WR;
            end
            RMW_WR: begin
                bus.CSram   = 1'b1;
                bus.EscrMem = 1'b1;
                bus.Direc   = widx_q;
                bus.Datain  = merged;
                state_nx    = RESP;
            end
`endif
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_sram.sv
// Self-checking bench for lsu_sram: directed vector table, multi-cycle corner sequences,
// and randomized accesses checked against a lane/shift-based reference model.
module tb_lsu_sram;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [9:0]  a;
        logic [31:0] wd;
        logic        e;
        logic [31:0] rd;
        int          lat;
        logic [31:0] word;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cs_total = 0;
    int   wr_total = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rdata;
    vec_t        tbl [16];

    lsu_sram_if bus ();

    lsu_sram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.CSram && bus.EscrMem) begin
            mem[bus.Direc] <= bus.Datain;
        end
    end

    assign bus.Dataout = bus.LeerMem ? mem[bus.Direc] : '0;

    always @(negedge clk) begin
        if (bus.CSram)   cs_total <= cs_total + 1;
        if (bus.EscrMem) wr_total <= wr_total + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: word-granular memory plus shift/mask lane arithmetic.
    task automatic predict(input vec_t v, output vec_t r);
        logic [31:0] cur, mask;
        int unsigned sh;
        r = v;
        cur = ref_mem[v.a[9:2]];
        r.e = (v.sz < 2'd2 && !SUB) || (v.sz == 2'd1 && v.a[0]) ||
              (v.sz >= 2'd2 && v.a[1:0] != 2'b00);
        r.rd = ref_rdata;
        r.word = cur;
        sh = (v.sz == 2'd0) ? 8 * v.a[1:0] : 16 * v.a[1];
        mask = (v.sz == 2'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
        if (r.e) begin
            r.lat = 1;
        end else if (!v.w) begin
            r.lat = 2;
            if (v.sz >= 2'd2) r.rd = cur;
            else begin
                r.rd = (cur & mask) >> sh;
                if (!v.u && v.sz == 2'd0 && r.rd[7])  r.rd = r.rd | 32'hFFFFFF00;
                if (!v.u && v.sz == 2'd1 && r.rd[15]) r.rd = r.rd | 32'hFFFF0000;
            end
        end else if (v.sz >= 2'd2) begin
            r.lat = 2;
            r.word = v.wd;
        end else begin
            r.lat = 3;
            r.word = (cur & ~mask) | ((v.wd << sh) & mask);
        end
    endtask

    task automatic commit(input vec_t r);
        ref_mem[r.a[9:2]] = r.word;
        ref_rdata = r.rd;
    endtask

    task automatic wait_done(input string nm, output int n);
        bit got = 1'b0;
        n = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (bus.done) got = 1'b1;
        end
        if (!got) chk({nm, " done timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drive(input vec_t v);
        bus.req = 1'b1;
        bus.we = v.w;
        bus.size = v.sz;
        bus.uns = v.u;
        bus.addr = v.a;
        bus.wdata = v.wd;
    endtask

    task automatic scramble();
        bus.we = 1'($urandom);
        bus.size = 2'($urandom);
        bus.uns = 1'($urandom);
        bus.addr = 10'($urandom);
        bus.wdata = $urandom;
    endtask

    task automatic run(input vec_t v, input string nm);
        vec_t m;
        int n, cs0, wr0;
        predict(v, m);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        scramble();
        cs0 = cs_total;
        wr0 = wr_total;
        chk({nm, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(nm, n);
        chk({nm, " latency"}, n, v.lat);
        chk({nm, " err"}, 32'(bus.err), 32'(v.e));
        chk({nm, " rdata"}, bus.rdata, v.rd);
        chk({nm, " resp strobes"}, {bus.CSram, bus.LeerMem, bus.EscrMem, bus.Direc, bus.Datain[20:0]}, 32'd0);
        chk({nm, " resp datain"}, bus.Datain, 32'd0);
        @(posedge clk);
        #1;
        chk({nm, " CSram cycles"}, cs_total - cs0, v.lat - 1);
        chk({nm, " write pulses"}, wr_total - wr0, (v.w && !v.e) ? 1 : 0);
        chk({nm, " mem word"}, mem[v.a[9:2]], v.word);
        @(negedge clk);
        chk({nm, " back idle"}, {30'd0, bus.done, bus.busy}, 32'd0);
        commit(m);
    endtask

    task automatic outs_zero(input string nm);
        chk({nm, " ctl"}, {26'd0, bus.busy, bus.done, bus.err, bus.CSram, bus.LeerMem, bus.EscrMem}, 32'd0);
        chk({nm, " Direc"}, 32'(bus.Direc), 32'd0);
        chk({nm, " Datain"}, bus.Datain, 32'd0);
        chk({nm, " rdata"}, bus.rdata, 32'd0);
    endtask

    initial begin
        vec_t v, m;
        int n;
        bus.req = 1'b0;
        scramble();
        ref_rdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        outs_zero("reset");
        @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;

        //         w     sz     u     addr     wdata          err   rdata                                lat          word after
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 10'h000, 32'h0,         !SUB, 32'h0,                               SUB ? 2 : 1, 32'h0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 10'h004, 32'hDEADBEEF,  1'b0, 32'h0,                               2,           32'hDEADBEEF};
        tbl[2]  = '{1'b0, 2'd2, 1'b0, 10'h004, 32'h0,         1'b0, 32'hDEADBEEF,                        2,           32'hDEADBEEF};
        tbl[3]  = '{1'b1, 2'd2, 1'b0, 10'h008, 32'h11223344,  1'b0, 32'hDEADBEEF,                        2,           32'h11223344};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 10'h00A, 32'hFFFFFFAB,  !SUB, 32'hDEADBEEF,                        SUB ? 3 : 1, SUB ? 32'h11AB3344 : 32'h11223344};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 10'h008, 32'h80FF7F01,  1'b0, 32'hDEADBEEF,                        2,           32'h80FF7F01};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 10'h009, 32'h0,         !SUB, SUB ? 32'h0000007F : 32'hDEADBEEF,   SUB ? 2 : 1, 32'h80FF7F01};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 10'h00A, 32'h0,         !SUB, SUB ? 32'hFFFFFFFF : 32'hDEADBEEF,   SUB ? 2 : 1, 32'h80FF7F01};
        tbl[8]  = '{1'b0, 2'd1, 1'b1, 10'h00A, 32'h0,         !SUB, SUB ? 32'h000080FF : 32'hDEADBEEF,   SUB ? 2 : 1, 32'h80FF7F01};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 10'h006, 32'h0,         1'b1, SUB ? 32'h000080FF : 32'hDEADBEEF,   1,           32'hDEADBEEF};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 10'h003, 32'h1234,      1'b1, SUB ? 32'h000080FF : 32'hDEADBEEF,   1,           32'h0};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 10'h00C, 32'h01020304,  1'b0, SUB ? 32'h000080FF : 32'hDEADBEEF,   2,           32'h01020304};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 10'h00E, 32'hFFFF5A5A,  !SUB, SUB ? 32'h000080FF : 32'hDEADBEEF,   SUB ? 3 : 1, SUB ? 32'h5A5A0304 : 32'h01020304};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 10'h00C, 32'h0,         !SUB, SUB ? 32'h00000304 : 32'hDEADBEEF,   SUB ? 2 : 1, SUB ? 32'h5A5A0304 : 32'h01020304};
        tbl[14] = '{1'b0, 2'd3, 1'b0, 10'h00C, 32'h0,         1'b0, SUB ? 32'h5A5A0304 : 32'h01020304,   2,           SUB ? 32'h5A5A0304 : 32'h01020304};
        tbl[15] = '{1'b0, 2'd0, 1'b1, 10'h00B, 32'h0,         !SUB, SUB ? 32'h00000080 : 32'h01020304,   SUB ? 2 : 1, 32'h80FF7F01};
        for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("vec%0d", i));

        // req held high through a store: the second request is taken only after IDLE returns
        v = '{1'b1, 2'd0, 1'b0, 10'h011, 32'h000000C3, 1'b0, 32'h0, 0, 32'h0};
        predict(v, m);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        bus.we = 1'b1;
        bus.size = 2'd2;
        bus.addr = 10'h014;
        bus.wdata = 32'h13579BDF;
        wait_done("held1", n);
        chk("held1 latency", n, m.lat);
        @(negedge clk);
        chk("held gap busy", 32'(bus.busy), 32'd0);
        chk("held1 word", mem[4], m.word);
        chk("held2 not early", mem[5], ref_mem[5]);
        commit(m);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        wait_done("held2", n);
        chk("held2 latency", n, 2);
        @(posedge clk);
        #1;
        chk("held2 word", mem[5], 32'h13579BDF);
        ref_mem[5] = 32'h13579BDF;

        // reset at the edge ending the first access cycle (RMW_RD, or READ without sub-word support)
        v = SUB ? '{1'b1, 2'd0, 1'b0, 10'h019, 32'h00000077, 1'b0, 32'h0, 0, 32'h0}
                : '{1'b0, 2'd2, 1'b0, 10'h018, 32'h0, 1'b0, 32'h0, 0, 32'h0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk("pre-reset rdata nonzero", 32'(bus.rdata != 32'd0), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        outs_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort mem", mem[6], ref_mem[6]);
        ref_rdata = '0;

        for (int i = 0; i < 60; i++) begin
            v.w = 1'($urandom);
            v.sz = 2'($urandom);
            v.u = 1'($urandom);
            v.a = 10'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (v.sz >= 2'd2) v.a[1:0] = 2'b00;
                if (v.sz == 2'd1) v.a[0] = 1'b0;
            end
            v.wd = $urandom;
            predict(v, m);
            run(m, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
